dp_share_ctrl: RTL and testbench
================================

// Module: dp_share_ctrl
// PURPOSE
//  Two-requester controller for one shared module_top datapath (12-bit a/b/c in, e strobe, y out).
//  Accepts operand triples on valid/ready ports and arbitrates them round-robin.
//  Issues one op at a time with a single-cycle e pulse, captures y after DP_LAT cycles,
//  and returns y to the granted requester. Sits between the requesters and module_top.
// PARAMETERS
//  W       12  operand/result width (a, b, c, y)
//  DP_LAT  2   cycles from the dp_e pulse to valid dp_y; legal range 1..15
// PORTS
//  clk          in   1  system clock, rising edge
//  rst          in   1  synchronous reset, active-high
//  req0_valid   in   1  requester 0 has an op
//  req0_ready   out  1  requester 0 op accepted this cycle
//  req0_a/b/c   in   W  requester 0 operands
//  req1_valid   in   1  requester 1 has an op
//  req1_ready   out  1  requester 1 op accepted this cycle
//  req1_a/b/c   in   W  requester 1 operands
//  rsp0_valid   out  1  result for requester 0 on rsp_y
//  rsp1_valid   out  1  result for requester 1 on rsp_y
//  rsp_ready    in   1  result consumer ready (shared)
//  rsp_y        out  W  result value
//  dp_a/b/c     out  W  datapath operands
//  dp_e         out  1  datapath enable strobe
//  dp_y         in   W  datapath result
//  busy         out  1  1 whenever state != IDLE
// BEHAVIOUR
//  - Reset values: all outputs 0, state IDLE, RR pointer favours req0, op regs 0, cnt 0.
//  - FSM states: IDLE, ISSUE, WAIT, RESP. At most one op is outstanding.
//  - IDLE:
//    - reqN_ready = grantN (combinational). Grant only if reqN_valid.
//    - If both requesters are valid, grant the one not served last.
//    - On a handshake: latch a/b/c and the grant id; next state ISSUE.
//  - ISSUE: dp_e=1 for exactly one cycle; dp_a/b/c = latched ops; cnt<=DP_LAT-1; next state WAIT.
//  - WAIT:
//    - if cnt==0: capture y_reg<=dp_y, next state RESP;
//    - else: cnt<=cnt-1.
//    - dp_y is therefore sampled exactly DP_LAT cycles after the dp_e cycle.
//  - RESP:
//    - rsp<id>_valid=1, rsp_y=y_reg; hold both stable until rsp_ready.
//    - On rsp_ready: pointer<=id, next state IDLE.
//    - If rsp_ready is already high, RESP lasts exactly 1 cycle.
//  - Latency: handshake at T -> dp_e at T+1 -> capture at T+1+DP_LAT -> rsp valid at T+2+DP_LAT.
//  - dp_a/b/c hold their last issued values outside ISSUE. dp_e=0 in all other states.
//  - reqN_ready=0 in every non-IDLE state. Requesters hold valid and data stable until ready.
//  - A new request is accepted no earlier than the cycle after the RESP handshake.
//    Max throughput: 1 op per DP_LAT+3 cycles.
//  - rsp_y is 0 outside RESP. rsp0_valid and rsp1_valid are never both 1.
//  - Reset mid-op (any state): op is abandoned, no response is issued,
//    and all outputs return to their reset values next cycle.
//  - No arithmetic other than cnt. cnt is 4 bits and never underflows.
// STRUCTURE
//  - dp_ctrl_defs.vh: W default, DP_LAT default, state encodings
//    (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3).
//  - Sub-module rr_arb2: 2-way round-robin arbiter
//    (req[1:0], en, last_id in -> one-hot grant).
//  - Top level: FSM, latency counter, operand/result regs, output muxing.
// TESTING
//  1. Reset: rst high 3 cycles, then low -> all outputs 0, busy=0, no dp_e pulse.
//  2. Single op, DP_LAT=2: req0 a=12'hDFC b=12'h5B4 c=12'h0E7 at T
//     -> req0_ready@T, dp_e@T+1 with those ops, dp_y sampled @T+3,
//        rsp0_valid@T+4 with rsp_y=the value sampled.
//  3. Contention: req0 and req1 both valid continuously, rsp_ready=1
//     -> grants alternate 0,1,0,1; 4 ops complete in 4*(DP_LAT+3) cycles.
//  4. Backpressure: rsp_ready=0 for 5 cycles in RESP
//     -> rsp1_valid and rsp_y stable, req*_ready=0, busy=1; completes the cycle rsp_ready=1.
//  5. Reset mid-op: rst asserted in WAIT
//     -> no rsp*_valid ever for that op; next op after reset is served normally.
//  6. DP_LAT=1 build: single op -> dp_y sampled the cycle after dp_e; rsp valid at T+3.

Source files
------------

// File: rtl/dp_share_ctrl_pkg.sv
// Shared definitions for the dp_share_ctrl slice: default operand width, default
// datapath latency and the controller state encoding.
package dp_share_ctrl_pkg;

  localparam int unsigned WDef     = 12;
  localparam int unsigned DpLatDef = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

endpackage

// File: rtl/dp_share_ctrl_if.sv
// Bus bundle between the two requesters, the result consumer, the shared datapath and
// the controller.
//   req0_* / req1_* : operand triples on valid/ready
//   rsp*_valid, rsp_ready, rsp_y : result return (consumer ready is shared)
//   dp_a/b/c, dp_e, dp_y : shared datapath operands, strobe and result
// Modports: slave = controller side, master = environment side.
interface dp_share_ctrl_if #(
  parameter int unsigned W = 12
) ();

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic [W-1:0] req0_c;
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic [W-1:0] req1_c;
  logic         rsp0_valid;
  logic         rsp1_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_y;
  logic [W-1:0] dp_a;
  logic [W-1:0] dp_b;
  logic [W-1:0] dp_c;
  logic         dp_e;
  logic [W-1:0] dp_y;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_c,
    input  req1_valid, req1_a, req1_b, req1_c,
    input  rsp_ready, dp_y,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_y,
    output dp_a, dp_b, dp_c, dp_e
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_c,
    output req1_valid, req1_a, req1_b, req1_c,
    output rsp_ready, dp_y,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_y,
    input  dp_a, dp_b, dp_c, dp_e
  );

endinterface

// File: rtl/dp_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter.
//   req     : request vector (bit N = requester N)
//   en      : grants allowed this cycle
//   last_id : id of the requester served last
//   grant   : one-hot grant, all zero when disabled or nothing requested
module dp_share_ctrl_rr_arb2 (
  input  logic [1:0] req,
  input  logic       en,
  input  logic       last_id,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        // Contention: favour whichever requester was not served last.
        grant = last_id ? 2'b01 : 2'b10;
      end else begin
        grant = req;
      end
    end
  end

endmodule

// File: rtl/dp_share_ctrl.sv
// Controller sharing one datapath between two requesters. Accepts one op at a time
// (round-robin on contention), pulses dp_e for one cycle, samples dp_y DP_LAT cycles
// later and returns the result to the granted requester, holding it until rsp_ready.
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : requester / response / datapath bundle (slave modport)
//   busy : high whenever the controller is not idle
module dp_share_ctrl
  import dp_share_ctrl_pkg::*;
#(
  parameter int unsigned W      = WDef,
  parameter int unsigned DP_LAT = DpLatDef  // legal 1..15
) (
  input  logic             clk,
  input  logic             rst,
  dp_share_ctrl_if.slave   bus,
  output logic             busy
);

  localparam logic [3:0] CntLoad = 4'(DP_LAT - 1);

  state_e       state_q;
  logic         ptr_q;   // id served last; reset value 1 favours req0
  logic         id_q;
  logic [3:0]   cnt_q;
  logic [W-1:0] dp_a_q, dp_b_q, dp_c_q, y_q;
  logic         dp_e_q, rsp0_q, rsp1_q, busy_q;
  logic [1:0]   grant;

  dp_share_ctrl_rr_arb2 u_arb (
    .req     ({bus.req1_valid, bus.req0_valid}),
    .en      (state_q == StIdle),
    .last_id (ptr_q),
    .grant   (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= 1'b1;
      id_q    <= 1'b0;
      cnt_q   <= 4'd0;
      dp_a_q  <= '0;
      dp_b_q  <= '0;
      dp_c_q  <= '0;
      y_q     <= '0;
      dp_e_q  <= 1'b0;
      rsp0_q  <= 1'b0;
      rsp1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      dp_e_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (|grant) begin
            id_q    <= grant[1];
            dp_a_q  <= grant[1] ? bus.req1_a : bus.req0_a;
            dp_b_q  <= grant[1] ? bus.req1_b : bus.req0_b;
            dp_c_q  <= grant[1] ? bus.req1_c : bus.req0_c;
            dp_e_q  <= 1'b1;  // high during the ISSUE cycle only
            busy_q  <= 1'b1;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          cnt_q   <= CntLoad;
          state_q <= StWait;
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            y_q     <= bus.dp_y;
            rsp0_q  <= ~id_q;
            rsp1_q  <= id_q;
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            ptr_q   <= id_q;
            rsp0_q  <= 1'b0;
            rsp1_q  <= 1'b0;
            y_q     <= '0;  // rsp_y reads zero outside RESP
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.dp_a       = dp_a_q;
  assign bus.dp_b       = dp_b_q;
  assign bus.dp_c       = dp_c_q;
  assign bus.dp_e       = dp_e_q;
  assign bus.rsp0_valid = rsp0_q;
  assign bus.rsp1_valid = rsp1_q;
  assign bus.rsp_y      = y_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_dp_share_ctrl.sv
// Directed bench for dp_share_ctrl: DP_LAT=2 and DP_LAT=1 instances side by side.
// dp_y follows a cycle-indexed pattern so the sampled cycle is visible in rsp_y.
module tb_dp_share_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic busy2, busy1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  int   t0, t1, c0, id, ph;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] f_y(input int c);
    return 12'(c * 37 + 21);
  endfunction

  dp_share_ctrl_if #(.W(12)) bus2 ();
  dp_share_ctrl_if #(.W(12)) bus1 ();

  assign bus2.dp_y = f_y(cyc);
  assign bus1.dp_y = f_y(cyc);

  dp_share_ctrl #(.W(12), .DP_LAT(2)) u_dut2 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus2),
    .busy (busy2)
  );

  dp_share_ctrl #(.W(12), .DP_LAT(1)) u_dut1 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus1),
    .busy (busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus2.req0_valid = 0; bus2.req0_a = 0; bus2.req0_b = 0; bus2.req0_c = 0;
    bus2.req1_valid = 0; bus2.req1_a = 0; bus2.req1_b = 0; bus2.req1_c = 0;
    bus2.rsp_ready = 1'b1;
    bus1.req0_valid = 0; bus1.req0_a = 0; bus1.req0_b = 0; bus1.req0_c = 0;
    bus1.req1_valid = 0; bus1.req1_a = 0; bus1.req1_b = 0; bus1.req1_c = 0;
    bus1.rsp_ready = 1'b1;

    // 1. Reset: 3 cycles high, then low.
    tick(); tick(); tick();
    chk("rst_busy", busy2, 0);
    chk("rst_dpe", bus2.dp_e, 0);
    chk("rst_rsp0", bus2.rsp0_valid, 0);
    chk("rst_rsp1", bus2.rsp1_valid, 0);
    chk("rst_rspy", bus2.rsp_y, 0);
    chk("rst_dpa", bus2.dp_a, 0);
    chk("rst_busy1", busy1, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_dpe", bus2.dp_e, 0);
      chk("post_rst_busy", busy2, 0);
    end

    // 2. Single op on req0, DP_LAT=2.
    tick();
    bus2.req0_valid = 1; bus2.req0_a = 12'hDFC; bus2.req0_b = 12'h5B4; bus2.req0_c = 12'h0E7;
    #1;
    t0 = cyc;
    chk("s_rdy0", bus2.req0_ready, 1);
    chk("s_rdy1", bus2.req1_ready, 0);
    tick();
    bus2.req0_valid = 0;
    #1;
    chk("s_dpe", bus2.dp_e, 1);
    chk("s_dpa", bus2.dp_a, 12'hDFC);
    chk("s_dpb", bus2.dp_b, 12'h5B4);
    chk("s_dpc", bus2.dp_c, 12'h0E7);
    chk("s_busy", busy2, 1);
    tick();
    chk("s_dpe_off", bus2.dp_e, 0);
    chk("s_dpa_hold", bus2.dp_a, 12'hDFC);
    tick();
    chk("s_rsp_early", bus2.rsp0_valid, 0);
    tick();
    chk("s_rsp0", bus2.rsp0_valid, 1);
    chk("s_rsp1", bus2.rsp1_valid, 0);
    chk("s_rspy", bus2.rsp_y, f_y(t0 + 3));
    tick();
    chk("s_rsp0_off", bus2.rsp0_valid, 0);
    chk("s_rspy_off", bus2.rsp_y, 0);
    chk("s_busy_off", busy2, 0);

    // 3. Contention from a fresh reset: grants alternate 0,1,0,1 every 5 cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus2.req0_valid = 1; bus2.req0_a = 12'h111; bus2.req0_b = 12'h222; bus2.req0_c = 12'h333;
    bus2.req1_valid = 1; bus2.req1_a = 12'h444; bus2.req1_b = 12'h555; bus2.req1_c = 12'h666;
    bus2.rsp_ready = 1;
    #1;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) tick();
      id = (k / 5) % 2;
      ph = k % 5;
      if (ph == 0) c0 = cyc;
      chk("c_rdy0", bus2.req0_ready, (ph == 0 && id == 0));
      chk("c_rdy1", bus2.req1_ready, (ph == 0 && id == 1));
      chk("c_rsp0", bus2.rsp0_valid, (ph == 4 && id == 0));
      chk("c_rsp1", bus2.rsp1_valid, (ph == 4 && id == 1));
      if (ph == 1) chk("c_dpa", bus2.dp_a, (id == 1) ? 12'h444 : 12'h111);
      if (ph == 4) chk("c_rspy", bus2.rsp_y, f_y(c0 + 3));
    end
    tick();
    bus2.req0_valid = 0; bus2.req1_valid = 0;
    #1;
    chk("c_done_busy", busy2, 0);

    // 4. Backpressure on a req1 op: hold RESP for 5 cycles.
    bus2.rsp_ready = 0;
    bus2.req1_valid = 1;
    #1;
    t0 = cyc;
    chk("b_rdy1", bus2.req1_ready, 1);
    tick();
    bus2.req1_valid = 0;
    bus2.req0_valid = 1;
    #1;
    chk("b_rdy0_busy", bus2.req0_ready, 0);
    for (int i = 2; i <= 9; i++) begin
      tick();
      if (i == 9) bus2.rsp_ready = 1;
      #1;
      if (i >= 4) begin
        chk("b_rsp1", bus2.rsp1_valid, 1);
        chk("b_rsp0", bus2.rsp0_valid, 0);
        chk("b_rspy", bus2.rsp_y, f_y(t0 + 3));
        chk("b_rdy0", bus2.req0_ready, 0);
        chk("b_busy", busy2, 1);
      end
    end
    tick();
    t1 = cyc;
    chk("b_rsp1_off", bus2.rsp1_valid, 0);
    chk("b_rspy_off", bus2.rsp_y, 0);
    chk("b_next_rdy0", bus2.req0_ready, 1);
    tick();
    bus2.req0_valid = 0;
    #1;
    chk("b_next_dpa", bus2.dp_a, 12'h111);
    tick(); tick(); tick();
    chk("b_next_rsp0", bus2.rsp0_valid, 1);
    chk("b_next_rspy", bus2.rsp_y, f_y(t1 + 3));
    tick();

    // 5. Reset while in WAIT: op abandoned, next op served normally.
    bus2.req0_valid = 1; bus2.req0_a = 12'hABC;
    #1;
    chk("r_rdy0", bus2.req0_ready, 1);
    tick();
    bus2.req0_valid = 0;
    tick();
    rst = 1'b1;
    #1;
    chk("r_busy_wait", busy2, 1);
    tick();
    rst = 1'b0;
    #1;
    chk("r_busy", busy2, 0);
    chk("r_dpa", bus2.dp_a, 0);
    chk("r_dpe", bus2.dp_e, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("r_no_rsp0", bus2.rsp0_valid, 0);
      chk("r_no_busy", busy2, 0);
    end
    bus2.req1_valid = 1; bus2.req1_a = 12'h7E1;
    #1;
    t0 = cyc;
    chk("r_new_rdy1", bus2.req1_ready, 1);
    tick();
    bus2.req1_valid = 0;
    #1;
    chk("r_new_dpa", bus2.dp_a, 12'h7E1);
    tick(); tick(); tick();
    chk("r_new_rsp1", bus2.rsp1_valid, 1);
    chk("r_new_rspy", bus2.rsp_y, f_y(t0 + 3));
    tick();

    // 6. DP_LAT=1 instance: sample the cycle after dp_e, response at T+3.
    bus1.req0_valid = 1; bus1.req0_a = 12'h3C5; bus1.req0_b = 12'h001; bus1.req0_c = 12'hFFF;
    #1;
    t0 = cyc;
    chk("l1_rdy0", bus1.req0_ready, 1);
    tick();
    bus1.req0_valid = 0;
    #1;
    chk("l1_dpe", bus1.dp_e, 1);
    chk("l1_dpa", bus1.dp_a, 12'h3C5);
    tick();
    chk("l1_dpe_off", bus1.dp_e, 0);
    chk("l1_rsp_early", bus1.rsp0_valid, 0);
    tick();
    chk("l1_rsp0", bus1.rsp0_valid, 1);
    chk("l1_rspy", bus1.rsp_y, f_y(t0 + 2));
    tick();
    chk("l1_rsp0_off", bus1.rsp0_valid, 0);
    chk("l1_busy_off", busy1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
